// File: rtl/token_embed_pkg.sv
// Shared definitions for token_embed: default sizes, FSM state type and
// the saturating add helper used when TOKEN_EMBED_SAT_EN is defined.
package embed_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int D_MODEL_DEF = 192;
    localparam int N_PATCH_DEF = 196;
    localparam int N_TOK_DEF   = N_PATCH_DEF + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLS   = 2'd1,
        ST_PATCH = 2'd2
    } state_t;

    // Adds two sign-extended operands and clamps the result to the signed
    // range of a w-bit value (w must be 31 or less).
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int unsigned        w
    );
        logic signed [32:0] s;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        s  = {a[31], a} + {b[31], b};
        hi = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo = -(33'sd1 <<< (w - 1));
        if (s > hi) begin
            return hi[31:0];
        end else if (s < lo) begin
            return lo[31:0];
        end else begin
            return s[31:0];
        end
    endfunction

endpackage

// File: rtl/token_embed_pos_table.sv
// pos_table: embedding/position table storage for token_embed.
// Synchronous write port, combinational read port, contents never reset.
module pos_table
    import embed_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = N_TOK_DEF * D_MODEL_DEF,
    parameter int ADDR_W = $clog2(N_TOK_DEF * D_MODEL_DEF)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write one entry; addresses beyond the table are dropped
    always_ff @(posedge clk) begin
        if (we && ({1'b0, waddr} < (ADDR_W + 1)'(DEPTH))) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/token_embed.sv
// token_embed: emits the class token followed by N_PATCH patch tokens, each
// patch element summed with its table entry, through one output register.
// Optional build macro: TOKEN_EMBED_SAT_EN (saturating sums; default wraps).
module token_embed
    import embed_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int D_MODEL = D_MODEL_DEF,
    parameter int N_PATCH = N_PATCH_DEF
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    init,
    output logic                                    ready,
    input  logic                                    tbl_we,
    input  logic [$clog2((N_PATCH+1)*D_MODEL)-1:0]  tbl_addr,
    input  logic [DATA_W-1:0]                       tbl_wdata,
    input  logic [DATA_W-1:0]                       in_data,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    output logic [DATA_W-1:0]                       out_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic                                    out_last_elem,
    output logic                                    out_last_tok
);

    localparam int N_TOK  = N_PATCH + 1;
    localparam int DEPTH  = N_TOK * D_MODEL;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int TOK_W  = $clog2(N_TOK);
    localparam int EL_W   = (D_MODEL > 1) ? $clog2(D_MODEL) : 1;

    localparam logic [EL_W-1:0]  EL_LAST  = EL_W'(D_MODEL - 1);
    localparam logic [TOK_W-1:0] TOK_LAST = TOK_W'(N_PATCH);

    state_t              state;
    state_t              state_next;
    logic [TOK_W-1:0]    tok;
    logic [EL_W-1:0]     el;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   tbl_rdata;
    logic                tbl_wr;
    logic                take_ok;
    logic                load;
    logic                start;
    logic                elem_last;
    logic [DATA_W-1:0]   addend;
    logic [DATA_W-1:0]   sum;

    assign take_ok = !out_valid || out_ready;
    assign tbl_wr  = tbl_we && ready && !reset;

    pos_table #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_pos_table (
        .clk   (clk),
        .we    (tbl_wr),
        .waddr (tbl_addr),
        .wdata (tbl_wdata),
        .raddr (rd_addr),
        .rdata (tbl_rdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, handshake and load decode
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        in_ready   = 1'b0;
        load       = 1'b0;
        start      = 1'b0;
        elem_last  = (el == EL_LAST);
        case (state)
            ST_IDLE: begin
                ready = !out_valid;
                if (init && !out_valid) begin
                    start      = 1'b1;
                    state_next = ST_CLS;
                end
            end
            ST_CLS: begin
                load = take_ok;
                if (load && elem_last) begin
                    state_next = ST_PATCH;
                end
            end
            ST_PATCH: begin
                in_ready = take_ok;
                load     = take_ok && in_valid;
                if (load && elem_last && (tok == TOK_LAST)) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Sequence order matches table order, so the read address is a plain
    // running count of emitted elements rather than tok*D_MODEL+el.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            tok     <= '0;
            el      <= '0;
            rd_addr <= '0;
        end else if (load) begin
            rd_addr <= rd_addr + 1'b1;
            if (elem_last) begin
                el  <= '0;
                tok <= tok + 1'b1;
            end else begin
                el  <= el + 1'b1;
            end
        end
    end

`ifdef TOKEN_EMBED_SAT_EN
    logic signed [31:0] sat_sum;

    // Saturating sum; the class token adds zero so it passes through
    always_comb begin
        addend  = (state == ST_PATCH) ? in_data : '0;
        sat_sum = sat_add({{(32-DATA_W){addend[DATA_W-1]}}, addend},
                          {{(32-DATA_W){tbl_rdata[DATA_W-1]}}, tbl_rdata},
                          DATA_W);
        sum     = sat_sum[DATA_W-1:0];
    end
`else
    logic [DATA_W:0] sum_ext;

    // Wrapping sum; the class token adds zero so it passes through
    always_comb begin
        addend  = (state == ST_PATCH) ? in_data : '0;
        sum_ext = {addend[DATA_W-1], addend} + {tbl_rdata[DATA_W-1], tbl_rdata};
        sum     = sum_ext[DATA_W-1:0];
    end
`endif

    // Output register: load on emit, clear valid once taken, hold while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_last_elem <= 1'b0;
            out_last_tok  <= 1'b0;
        end else if (load) begin
            out_valid     <= 1'b1;
            out_data      <= sum;
            out_last_elem <= elem_last;
            out_last_tok  <= (tok == TOK_LAST);
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_token_embed.sv
// Self-checking bench for token_embed (DATA_W=8, D_MODEL=4, N_PATCH=2).
module tb_token_embed;

    localparam int DW  = 8;
    localparam int DM  = 4;
    localparam int NP  = 2;
    localparam int NT  = NP + 1;
    localparam int TOT = NT * DM;
    localparam int AW  = $clog2(TOT);

    logic          clk;
    logic          reset;
    logic          init;
    logic          ready;
    logic          tbl_we;
    logic [AW-1:0] tbl_addr;
    logic [DW-1:0] tbl_wdata;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last_elem;
    logic          out_last_tok;

    int errors = 0;
    int checks = 0;

    logic [7:0] tbl_m [TOT];
    logic [7:0] pdata [NP*DM];
    logic [7:0] got   [TOT];

    token_embed #(
        .DATA_W  (DW),
        .D_MODEL (DM),
        .N_PATCH (NP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .init          (init),
        .ready         (ready),
        .tbl_we        (tbl_we),
        .tbl_addr      (tbl_addr),
        .tbl_wdata     (tbl_wdata),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last_elem (out_last_elem),
        .out_last_tok  (out_last_tok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: token 0 is the raw table row; patch tokens add the patch
    // element to the table entry, then clamp or wrap to 8 bits.
    function automatic logic [7:0] model(input int t, input int e);
        int a;
        int b;
        int s;
        if (t == 0) return tbl_m[e];
        a = $signed(pdata[(t-1)*DM + e]);
        b = $signed(tbl_m[t*DM + e]);
        s = a + b;
`ifdef TOKEN_EMBED_SAT_EN
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
`endif
        return s[7:0];
    endfunction

    task automatic write_tbl(input int addr, input logic [7:0] data);
        @(negedge clk);
        tbl_we    = 1'b1;
        tbl_addr  = AW'(addr);
        tbl_wdata = data;
        @(negedge clk);
        tbl_we    = 1'b0;
        tbl_m[addr] = data;
    endtask

    // mode: 0 full speed, 1 out_ready toggling, 2 random handshakes
    // fault: 0 none, 1 reset after 6th output, 2 init/tbl_we pulse mid-PATCH
    task automatic run_image(input int mode, input int fault);
        logic [7:0] exp_q [$];
        logic       exp_le [$];
        logic       exp_lt [$];
        int   k = 0;
        int   idx = 0;
        int   cyc = 0;
        int   first = -1;
        int   last = -1;
        int   loaded;
        bit   held = 0;
        bit   injected = 0;
        logic [7:0] h_data;
        logic h_le;
        logic h_lt;
        logic exp_ir;
        for (int t = 0; t < NT; t++) begin
            for (int e = 0; e < DM; e++) begin
                exp_q.push_back(model(t, e));
                exp_le.push_back(e == DM - 1);
                exp_lt.push_back(t == NT - 1);
            end
        end
        @(negedge clk);
        init = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        while (k < TOT && cyc < 400) begin
            @(negedge clk);
            init = 1'b0; tbl_we = 1'b0;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            in_valid = (mode == 2) ? ($urandom_range(0, 9) < 7) : 1'b1;
            in_data  = (idx < NP*DM) ? pdata[idx] : 8'($urandom);
            if (fault == 2 && k == 6 && !injected) begin
                init = 1'b1; tbl_we = 1'b1; tbl_addr = '0; tbl_wdata = 8'h5A;
                injected = 1;
            end
            #1;
            loaded = k + int'(out_valid);
            exp_ir = (loaded >= DM) && (loaded < TOT) && (!out_valid || out_ready);
            check("in_ready", in_ready, exp_ir);
            if (held) begin
                check("stall_data", out_data, h_data);
                check("stall_last_elem", out_last_elem, h_le);
                check("stall_last_tok", out_last_tok, h_lt);
            end
            held = 0;
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    check("out_data", out_data, exp_q[k]);
                    check("out_last_elem", out_last_elem, exp_le[k]);
                    check("out_last_tok", out_last_tok, exp_lt[k]);
                    got[k] = out_data;
                    if (first < 0) first = cyc;
                    last = cyc;
                    k++;
                end else begin
                    held = 1; h_data = out_data; h_le = out_last_elem; h_lt = out_last_tok;
                end
            end
            if (in_valid && in_ready) idx++;
            cyc++;
            if (fault == 1 && k == 6) break;
        end
        if (fault == 1) begin
            check("reset_point", k, 6);
            @(negedge clk);
            reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            #1;
            check("rst_mid_out_valid", out_valid, 1'b0);
            check("rst_mid_ready", ready, 1'b1);
            check("rst_mid_in_ready", in_ready, 1'b0);
            return;
        end
        check("complete", k, TOT);
        check("in_count", idx, NP*DM);
        if (mode == 0) check("throughput", last - first + 1, TOT);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; init = 1'b0; tbl_we = 1'b0;
        #1;
        check("end_ready", ready, 1'b1);
        check("end_out_valid", out_valid, 1'b0);
    endtask

    initial begin
        int lit [TOT] = '{0, 1, 2, 3, 14, 15, 16, 17, 18, 19, 20, 21};
        logic [7:0] exp4;
        logic [7:0] exp5;
        reset = 1'b1; init = 1'b0; tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_last_elem", out_last_elem, 1'b0);
        check("rst_last_tok", out_last_tok, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_ready", ready, 1'b1);
        reset = 1'b0;

        for (int i = 0; i < TOT; i++) write_tbl(i, 8'(i));

        // reset beats init and tbl_we in the same cycle
        @(negedge clk);
        reset = 1'b1; init = 1'b1; tbl_we = 1'b1; tbl_addr = '0; tbl_wdata = 8'h77;
        @(negedge clk);
        reset = 1'b0; init = 1'b0; tbl_we = 1'b0;
        #1;
        check("rst_prio_ready", ready, 1'b1);
        check("rst_prio_out_valid", out_valid, 1'b0);

        for (int i = 0; i < NP*DM; i++) pdata[i] = 8'd10;
        run_image(0, 0);
        for (int i = 0; i < TOT; i++) check("literal_seq", got[i], 8'(lit[i]));

        run_image(1, 0);
        run_image(0, 1);
        run_image(0, 0);
        run_image(0, 2);
        run_image(0, 0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < TOT; i++) write_tbl(i, 8'($urandom));
            for (int i = 0; i < NP*DM; i++) pdata[i] = 8'($urandom);
            run_image(2, 0);
        end

        for (int i = 0; i < TOT; i++) write_tbl(i, 8'(i));
        write_tbl(4, 8'd100);
        write_tbl(5, 8'h9C);
        for (int i = 0; i < NP*DM; i++) pdata[i] = 8'd10;
        pdata[0] = 8'd100;
        pdata[1] = 8'h9C;
        run_image(0, 0);
`ifdef TOKEN_EMBED_SAT_EN
        exp4 = 8'h7F; exp5 = 8'h80;
`else
        exp4 = 8'hC8; exp5 = 8'h38;
`endif
        check("sum_pos_overflow", got[4], exp4);
        check("sum_neg_overflow", got[5], exp5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
